// File: rtl/instruction_scheduler.sv
// Four-slot out-of-order issue scheduler with an age matrix and RAW/WAW/WAR hazard checks.
// Optional SCHED_FORWARD_EN lets a DONE producer stop blocking its dependents.
module instruction_scheduler #(
  parameter int LAT_ADD = 1,
  parameter int LAT_SUB = 1,
  parameter int LAT_MUL = 3,
  parameter int LAT_LD  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_flat_in,
  input  logic [3:0]  valid_bits_in,
  output logic [3:0]  retire_onehot,
  output logic        issue_valid,
  output logic [1:0]  issue_slot,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } slot_state_t;

  slot_state_t r_state [4];
  slot_state_t w_state_nxt [4];
  logic [2:0]  r_cnt  [4];
  logic [2:0]  w_cnt_nxt [4];
  logic [1:0]  r_op   [4];
  logic [1:0]  r_src1 [4];
  logic [1:0]  r_src2 [4];
  logic [1:0]  r_dest [4];
  logic [1:0]  w_op_nxt   [4];
  logic [1:0]  w_src1_nxt [4];
  logic [1:0]  w_src2_nxt [4];
  logic [1:0]  w_dest_nxt [4];
  // r_age[i][k] set means slot k is older than slot i.
  logic [3:0]  r_age [4];
  logic [3:0]  w_age_nxt [4];
  logic        r_issue_valid;
  logic [1:0]  r_issue_slot;

  logic [3:0]  w_arrive;
  logic [3:0]  w_kill;
  logic [3:0]  w_leave;
  logic [3:0]  w_blocker;
  logic [3:0]  w_ready;
  logic [3:0]  w_sel;
  logic        w_any_sel;
  logic [1:0]  w_sel_idx;

  function automatic logic [2:0] lat_m1(input logic [1:0] op);
    case (op)
      2'b00:   lat_m1 = 3'(LAT_ADD - 1);
      2'b01:   lat_m1 = 3'(LAT_SUB - 1);
      2'b10:   lat_m1 = 3'(LAT_MUL - 1);
      default: lat_m1 = 3'(LAT_LD - 1);
    endcase
  endfunction

  always_comb begin
    w_arrive  = '0;
    w_kill    = '0;
    w_leave   = '0;
    w_blocker = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_arrive[i] = (r_state[i] == S_EMPTY) && valid_bits_in[i];
      w_kill[i]   = ((r_state[i] == S_WAIT) || (r_state[i] == S_EXEC)) && !valid_bits_in[i];
      w_leave[i]  = w_kill[i] || (r_state[i] == S_DONE);
`ifdef SCHED_FORWARD_EN
      w_blocker[i] = (r_state[i] == S_WAIT) || (r_state[i] == S_EXEC);
`else
      w_blocker[i] = (r_state[i] != S_EMPTY);
`endif
    end
  end

  always_comb begin
    w_ready = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      w_ready[j] = (r_state[j] == S_WAIT) && valid_bits_in[j];
      for (int unsigned k = 0; k < 4; k++) begin
        if (k != j && r_age[j][k]) begin
          if (w_blocker[k] && ((r_dest[k] == r_src1[j]) || (r_dest[k] == r_src2[j]) ||
                               (r_dest[k] == r_dest[j])))
            w_ready[j] = 1'b0;
          if ((r_state[k] == S_WAIT) && ((r_src1[k] == r_dest[j]) || (r_src2[k] == r_dest[j])))
            w_ready[j] = 1'b0;
        end
      end
    end
  end

  // The age matrix is a total order over live slots, so at most one ready slot has no older ready peer.
  always_comb begin
    w_sel     = '0;
    w_sel_idx = '0;
    for (int unsigned j = 0; j < 4; j++)
      w_sel[j] = w_ready[j] && ((w_ready & r_age[j]) == 4'b0000);
    w_any_sel = |w_sel;
    for (int unsigned j = 0; j < 4; j++)
      if (w_sel[j]) w_sel_idx = 2'(j);
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_op_nxt[i]    = r_op[i];
      w_src1_nxt[i]  = r_src1[i];
      w_src2_nxt[i]  = r_src2[i];
      w_dest_nxt[i]  = r_dest[i];
      case (r_state[i])
        S_EMPTY: begin
          if (w_arrive[i]) begin
            w_state_nxt[i] = S_WAIT;
            w_op_nxt[i]    = instr_flat_in[8*i+6 +: 2];
            w_src1_nxt[i]  = instr_flat_in[8*i+4 +: 2];
            w_src2_nxt[i]  = instr_flat_in[8*i+2 +: 2];
            w_dest_nxt[i]  = instr_flat_in[8*i   +: 2];
          end
        end
        S_WAIT: begin
          if (w_kill[i]) begin
            w_state_nxt[i] = S_EMPTY;
          end else if (w_sel[i]) begin
            w_state_nxt[i] = S_EXEC;
            w_cnt_nxt[i]   = lat_m1(r_op[i]);
          end
        end
        S_EXEC: begin
          if (w_kill[i]) begin
            w_state_nxt[i] = S_EMPTY;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == 3'd0) begin
            w_state_nxt[i] = S_DONE;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - 3'd1;
          end
        end
        default: begin
          w_state_nxt[i] = S_EMPTY;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // A new arrival is younger than every live slot; simultaneous arrivals rank lower index as older.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_age_nxt[i] = '0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (i == k || w_leave[i] || w_leave[k])
          w_age_nxt[i][k] = 1'b0;
        else if (w_arrive[i])
          w_age_nxt[i][k] = (r_state[k] != S_EMPTY) || (w_arrive[k] && (k < i));
        else if (w_arrive[k] || (r_state[i] == S_EMPTY))
          w_age_nxt[i][k] = 1'b0;
        else
          w_age_nxt[i][k] = r_age[i][k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i] <= S_EMPTY;
        r_cnt[i]   <= '0;
        r_op[i]    <= '0;
        r_src1[i]  <= '0;
        r_src2[i]  <= '0;
        r_dest[i]  <= '0;
        r_age[i]   <= '0;
      end
      r_issue_valid <= 1'b0;
      r_issue_slot  <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_op[i]    <= w_op_nxt[i];
        r_src1[i]  <= w_src1_nxt[i];
        r_src2[i]  <= w_src2_nxt[i];
        r_dest[i]  <= w_dest_nxt[i];
        r_age[i]   <= w_age_nxt[i];
      end
      r_issue_valid <= w_any_sel;
      r_issue_slot  <= w_any_sel ? w_sel_idx : 2'd0;
    end
  end

  always_comb begin
    retire_onehot = '0;
    busy          = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      retire_onehot[i] = (r_state[i] == S_DONE);
      if (r_state[i] != S_EMPTY) busy = 1'b1;
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_slot  = r_issue_slot;

endmodule

// File: doc/instruction_scheduler.md
INSTRUCTION_SCHEDULER -- requirements
Module: instruction_scheduler

Interface
REQ-001: Parameter LAT_ADD, default 1, execution cycles for opcode 2'b00.
REQ-002: Parameter LAT_SUB, default 1, execution cycles for opcode 2'b01.
REQ-003: Parameter LAT_MUL, default 3, execution cycles for opcode 2'b10.
REQ-004: Parameter LAT_LD, default 2, execution cycles for opcode 2'b11; all LAT_* SHALL be in the range 1..8.
REQ-005: Port clk, input, 1, single clock, rising edge.
REQ-006: Port reset_n, input, 1, asynchronous active-low reset.
REQ-007: Port instr_flat_in, input, 32, 4x8-bit queue window; slot i occupies bits [8i+7:8i] as {opcode, src1, src2, dest}, 2 bits each.
REQ-008: Port valid_bits_in, input, 4, per-slot valid from the queue.
REQ-009: Port retire_onehot, output, 4, registered per-slot retire pulse to the queue.
REQ-010: Port issue_valid, output, 1, registered pulse in the first execute cycle of an issued slot.
REQ-011: Port issue_slot, output, 2, slot index issued; 0 when issue_valid is low.
REQ-012: Port busy, output, 1, high while any slot state is not EMPTY.

Function
REQ-013: Each slot SHALL have a state EMPTY, WAIT, EXEC, or DONE, plus a 3-bit countdown and latched opcode/src1/src2/dest.
REQ-014: EMPTY->WAIT SHALL occur on the edge where valid_bits_in[i]=1, latching the slot fields; this is the arrival.
REQ-015: On arrival, slot i SHALL be marked younger than every non-EMPTY slot in the age matrix.
REQ-016: Simultaneous arrivals SHALL order the lower index as older.
REQ-017: A WAIT slot j SHALL be ready when no older non-EMPTY slot k has dest_k equal to src1_j, src2_j, or dest_j (RAW/WAW).
REQ-018: A WAIT slot j SHALL also be ready only when no older WAIT slot k has src1_k or src2_k equal to dest_j (WAR).
REQ-019: At most one slot SHALL issue per cycle, the oldest ready slot.
REQ-020: An issuing slot SHALL go WAIT->EXEC with countdown = LAT(opcode)-1; issue_valid and issue_slot SHALL be asserted during that first EXEC cycle.
REQ-021: The countdown SHALL decrement once per cycle while in EXEC; at 0, EXEC->DONE on the next edge.
REQ-022: The execution unit is pipelined: EXEC slots SHALL NOT block issue of other slots.
REQ-023: retire_onehot[i] SHALL be 1 exactly during the single DONE cycle; multiple bits may be set in the same cycle.
REQ-024: DONE->EMPTY SHALL occur unconditionally on the next edge, clearing the age-matrix row and column; valid_bits_in[i] is ignored in that cycle.
REQ-025: Timing: arrival sampled in cycle A gives earliest issue_valid at A+2 and retire pulse at A+2+LAT.
REQ-026: If valid_bits_in[i]=0 while slot i is WAIT or EXEC, the slot SHALL go EMPTY on the next edge without a retire pulse.

Reset
REQ-027: reset_n=0 SHALL immediately set all slots EMPTY, clear age matrix and countdowns, and drive retire_onehot=0, issue_valid=0, issue_slot=0, busy=0.
REQ-028: Reset asserted mid-execution SHALL discard in-flight work; no retire pulse SHALL follow reset deassertion.

Configuration
REQ-029: Macro SCHED_FORWARD_EN defined: an older slot in DONE SHALL NOT block a younger slot in REQ-017, so a dependent issues in the producer's DONE cycle.
REQ-030: Macro SCHED_FORWARD_EN undefined: the producer SHALL block until it is EMPTY, so a dependent issues no earlier than one cycle after the producer's retire pulse.

Verification
REQ-031: ADD 0x06 arrives in slot0 in cycle 0 -> issue_valid=1 with issue_slot=0 in cycle 2; retire_onehot=0001 in cycle 3; busy=0 in cycle 4.
REQ-032: 0x06 in slot0 (cycle 0), then MUL 0xAB in slot1 (cycle 1) -> MUL issue_valid at cycle 4 and retire 0010 at cycle 7 with SCHED_FORWARD_EN; cycle 5 and cycle 8 without it.
REQ-033: LD 0xC1 in slot0 (cycle 0), then ADD 0x02 in slot1 (cycle 1) -> issues in cycles 2 and 3; retire_onehot=0011 in cycle 4.
REQ-034: Slot1 holds MUL 0xAB; slot0 refills later with an ADD writing R2 -> the refilled slot0 is treated as younger and waits on WAR against slot1 despite its lower index.
REQ-035: reset_n pulsed low during cycle 3 of a MUL execute -> all outputs are 0 immediately; no retire pulse appears afterwards.
